// File: rtl/tl_pkg.sv
// Shared intersection definitions: lamp codes, phase IDs, phase lamp patterns and default dwells.
// Used by both the controller and the light monitor.
package tl_pkg;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    typedef enum logic [2:0] {
        PH_NONE = 3'd0,
        PH_1    = 3'd1,
        PH_2    = 3'd2,
        PH_3    = 3'd3,
        PH_4    = 3'd4,
        PH_5    = 3'd5,
        PH_6    = 3'd6
    } phase_t;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } mon_state_t;

    // Pattern layout is {M1, M2, MT, S}
    localparam logic [11:0] PAT_P1 = {LAMP_GRN, LAMP_GRN, LAMP_RED, LAMP_RED};
    localparam logic [11:0] PAT_P2 = {LAMP_GRN, LAMP_YEL, LAMP_RED, LAMP_RED};
    localparam logic [11:0] PAT_P3 = {LAMP_GRN, LAMP_RED, LAMP_GRN, LAMP_RED};
    localparam logic [11:0] PAT_P4 = {LAMP_YEL, LAMP_RED, LAMP_YEL, LAMP_RED};
    localparam logic [11:0] PAT_P5 = {LAMP_RED, LAMP_RED, LAMP_RED, LAMP_GRN};
    localparam logic [11:0] PAT_P6 = {LAMP_RED, LAMP_RED, LAMP_RED, LAMP_YEL};

    localparam int DWELL_P1_DEF = 8;
    localparam int DWELL_P2_DEF = 3;
    localparam int DWELL_P3_DEF = 6;
    localparam int DWELL_P4_DEF = 3;
    localparam int DWELL_P5_DEF = 4;
    localparam int DWELL_P6_DEF = 3;

    function automatic logic is_lamp(input logic [2:0] code);
        return (code == LAMP_RED) || (code == LAMP_YEL) || (code == LAMP_GRN);
    endfunction

    function automatic phase_t next_phase(input phase_t p);
        phase_t n;
        case (p)
            PH_1:    n = PH_2;
            PH_2:    n = PH_3;
            PH_3:    n = PH_4;
            PH_4:    n = PH_5;
            PH_5:    n = PH_6;
            PH_6:    n = PH_1;
            default: n = PH_NONE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/tl_light_monitor_if.sv
// The four 3-bit lamp buses between the intersection controller and anything observing them.
interface tl_light_monitor_if;

    logic [2:0] light_M1;
    logic [2:0] light_M2;
    logic [2:0] light_MT;
    logic [2:0] light_S;

    modport master (output light_M1, light_M2, light_MT, light_S);
    modport slave  (input  light_M1, light_M2, light_MT, light_S);

endinterface

// File: rtl/tl_phase_decoder.sv
// Combinational classification of the four lamp buses: conflict, then illegal, then phase 1..6.
module tl_phase_decoder
    import tl_pkg::*;
(
    input  logic [2:0] light_m1,
    input  logic [2:0] light_m2,
    input  logic [2:0] light_mt,
    input  logic [2:0] light_s,
    output phase_t     phase,
    output logic       valid,
    output logic       conflict,
    output logic       illegal
);

    logic [11:0] pat;
    logic        lamps_ok;
    phase_t      match;

    always_comb begin
        pat      = {light_m1, light_m2, light_mt, light_s};
        lamps_ok = is_lamp(light_m1) && is_lamp(light_m2) &&
                   is_lamp(light_mt) && is_lamp(light_s);
        conflict = (light_s != LAMP_RED) &&
                   ((light_m1 != LAMP_RED) || (light_m2 != LAMP_RED) || (light_mt != LAMP_RED));

        match = PH_NONE;
        case (pat)
            PAT_P1:  match = PH_1;
            PAT_P2:  match = PH_2;
            PAT_P3:  match = PH_3;
            PAT_P4:  match = PH_4;
            PAT_P5:  match = PH_5;
            PAT_P6:  match = PH_6;
            default: match = PH_NONE;
        endcase

        illegal = !conflict && (!lamps_ok || (match == PH_NONE));
        valid   = !conflict && !illegal;
        phase   = valid ? match : PH_NONE;
    end

endmodule

// File: rtl/tl_light_monitor.sv
// Passive checker of the controller lamp buses: decodes phases, tracks sequence and dwell,
// and pulses one error per sample with a saturating error total.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_HUNT   | no phase known; waiting for any valid phase pattern
//   ST_ALIGN  | phase known but entered mid-way; dwell not yet trustworthy
//   ST_LOCKED | following the sequence; dwell checked on every sample
module tl_light_monitor
    import tl_pkg::*;
#(
    parameter int DWELL_P1  = DWELL_P1_DEF,
    parameter int DWELL_P2  = DWELL_P2_DEF,
    parameter int DWELL_P3  = DWELL_P3_DEF,
    parameter int DWELL_P4  = DWELL_P4_DEF,
    parameter int DWELL_P5  = DWELL_P5_DEF,
    parameter int DWELL_P6  = DWELL_P6_DEF,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    tl_light_monitor_if.slave    lights,
    output logic [2:0]           phase,
    output logic                 locked,
    output logic                 cycle_done,
    output logic                 err_conflict,
    output logic                 err_illegal,
    output logic                 err_sequence,
    output logic                 err_dwell,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic [2:0] s1_m1, s1_m2, s1_mt, s1_s;
    logic       s1_vld;

    phase_t     dec_phase;
    logic       dec_valid, dec_conflict, dec_illegal;

    mon_state_t state;
    phase_t     cur_phase;
    phase_t     succ;
    logic [4:0] dwell;
    logic [4:0] dwell_lim;
    logic       is_same, is_succ, dwell_over, dwell_bad, err_now;

    // s1_vld keeps the reset contents of stage 1 from being judged as a lamp pattern
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_m1  <= LAMP_RED;
            s1_m2  <= LAMP_RED;
            s1_mt  <= LAMP_RED;
            s1_s   <= LAMP_RED;
            s1_vld <= 1'b0;
        end else begin
            s1_m1  <= lights.light_M1;
            s1_m2  <= lights.light_M2;
            s1_mt  <= lights.light_MT;
            s1_s   <= lights.light_S;
            s1_vld <= 1'b1;
        end
    end

    tl_phase_decoder u_decoder (
        .light_m1 (s1_m1),
        .light_m2 (s1_m2),
        .light_mt (s1_mt),
        .light_s  (s1_s),
        .phase    (dec_phase),
        .valid    (dec_valid),
        .conflict (dec_conflict),
        .illegal  (dec_illegal)
    );

    always_comb begin
        dwell_lim = 5'd31;
        case (cur_phase)
            PH_1:    dwell_lim = 5'(DWELL_P1);
            PH_2:    dwell_lim = 5'(DWELL_P2);
            PH_3:    dwell_lim = 5'(DWELL_P3);
            PH_4:    dwell_lim = 5'(DWELL_P4);
            PH_5:    dwell_lim = 5'(DWELL_P5);
            PH_6:    dwell_lim = 5'(DWELL_P6);
            default: dwell_lim = 5'd31;
        endcase

        succ       = next_phase(cur_phase);
        is_same    = dec_valid && (dec_phase == cur_phase);
        is_succ    = dec_valid && (dec_phase == succ);
        dwell_over = (dwell >= dwell_lim);
        dwell_bad  = (dwell != dwell_lim);

        err_now = 1'b0;
        if (s1_vld) begin
            if (dec_conflict || dec_illegal)
                err_now = 1'b1;
            else if ((state != ST_HUNT) && !is_same && !is_succ)
                err_now = 1'b1;
            else if ((state == ST_LOCKED) &&
                     ((is_same && dwell_over) || (is_succ && dwell_bad)))
                err_now = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_HUNT;
            cur_phase    <= PH_NONE;
            dwell        <= 5'd0;
            locked       <= 1'b0;
            cycle_done   <= 1'b0;
            err_conflict <= 1'b0;
            err_illegal  <= 1'b0;
            err_sequence <= 1'b0;
            err_dwell    <= 1'b0;
            err_count    <= '0;
        end else begin
            cycle_done   <= 1'b0;
            err_conflict <= 1'b0;
            err_illegal  <= 1'b0;
            err_sequence <= 1'b0;
            err_dwell    <= 1'b0;

            if (s1_vld) begin
                if (dec_conflict || dec_illegal) begin
                    err_conflict <= dec_conflict;
                    err_illegal  <= dec_illegal;
                    state        <= ST_HUNT;
                    cur_phase    <= PH_NONE;
                    dwell        <= 5'd0;
                    locked       <= 1'b0;
                end else begin
                    case (state)
                        ST_HUNT: begin
                            state     <= ST_ALIGN;
                            cur_phase <= dec_phase;
                            dwell     <= 5'd1;
                        end
                        ST_ALIGN: begin
                            if (is_same) begin
                                dwell <= (dwell == 5'd31) ? dwell : dwell + 5'd1;
                            end else begin
                                if (is_succ) begin
                                    state  <= ST_LOCKED;
                                    locked <= 1'b1;
                                end else begin
                                    err_sequence <= 1'b1;
                                end
                                cur_phase <= dec_phase;
                                dwell     <= 5'd1;
                            end
                        end
                        ST_LOCKED: begin
                            if (is_same) begin
                                if (dwell_over) begin
                                    err_dwell <= 1'b1;
                                    state     <= ST_HUNT;
                                    cur_phase <= PH_NONE;
                                    dwell     <= 5'd0;
                                    locked    <= 1'b0;
                                end else begin
                                    dwell <= dwell + 5'd1;
                                end
                            end else if (is_succ) begin
                                err_dwell  <= dwell_bad;
                                cycle_done <= (cur_phase == PH_6);
                                cur_phase  <= dec_phase;
                                dwell      <= 5'd1;
                            end else begin
                                err_sequence <= 1'b1;
                                state        <= ST_ALIGN;
                                locked       <= 1'b0;
                                cur_phase    <= dec_phase;
                                dwell        <= 5'd1;
                            end
                        end
                        default: begin
                            state     <= ST_HUNT;
                            cur_phase <= PH_NONE;
                            dwell     <= 5'd0;
                            locked    <= 1'b0;
                        end
                    endcase
                end

                if (err_now && (err_count != {ERR_CNT_W{1'b1}}))
                    err_count <= err_count + 1'b1;
            end
        end
    end

    assign phase = cur_phase;

endmodule
